// File: rtl/x_counter_updown_mod.sv
// rtl/x_counter_updown_mod.sv - parametrised up/down modulo counter with registered terminal-count pulse
// Define X_COUNTER_UPDOWN_MOD_SAT_EN to saturate at 0/MOD_MAX instead of wrapping.
module x_counter_updown_mod #(
    parameter int WIDTH     = 8,
    parameter int MOD_MAX   = 255,
    parameter int RESET_VAL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_zero
);

    if (WIDTH < 1 || WIDTH > 16 || MOD_MAX < 1 || MOD_MAX > (2**WIDTH) - 1 ||
        RESET_VAL < 0 || RESET_VAL > MOD_MAX) begin : g_param_err
        $error("x_counter_updown_mod: illegal WIDTH/MOD_MAX/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MOD_MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   up_ext;
    logic [WIDTH:0]   dn_ext;
    logic [WIDTH:0]   load_ext;

    // One extra bit so the up-step can exceed MOD_MAX and the down-step can borrow visibly.
    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        cnt_ext  = {1'b0, count_q};
        up_ext   = cnt_ext + (WIDTH+1)'(1);
        dn_ext   = cnt_ext - (WIDTH+1)'(1);
        load_ext = {1'b0, i_load_val};

        if (i_clr) begin
            count_d = RST_W;
        end else if (i_load) begin
            count_d = (load_ext > MAX_EXT) ? MAX_W : i_load_val;
        end else if (i_en) begin
            if (i_dir) begin
`ifdef X_COUNTER_UPDOWN_MOD_SAT_EN
                if (up_ext > MAX_EXT) begin
                    count_d = MAX_W;
                end else begin
                    count_d = up_ext[WIDTH-1:0];
                    tc_d    = (up_ext == MAX_EXT);
                end
`else
                if (up_ext > MAX_EXT) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = up_ext[WIDTH-1:0];
                end
`endif
            end else begin
`ifdef X_COUNTER_UPDOWN_MOD_SAT_EN
                if (dn_ext[WIDTH]) begin
                    count_d = '0;
                end else begin
                    count_d = dn_ext[WIDTH-1:0];
                    tc_d    = (dn_ext == '0);
                end
`else
                if (dn_ext[WIDTH]) begin
                    count_d = MAX_W;
                    tc_d    = 1'b1;
                end else begin
                    count_d = dn_ext[WIDTH-1:0];
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= RST_W;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;
    assign o_zero  = (count_q == '0);

endmodule

// File: tb/tb_x_counter_updown_mod.sv
// tb/tb_x_counter_updown_mod.sv - scoreboard bench for x_counter_updown_mod (8-bit/255 and 4-bit/9 instances)
module tb_x_counter_updown_mod;

`ifdef X_COUNTER_UPDOWN_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int A_MAX = 255;
    localparam int A_RST = 0;
    localparam int B_MAX = 9;
    localparam int B_RST = 3;

    typedef struct {
        int ca;
        bit tca;
        int cb;
        bit tcb;
    } exp_t;

    logic       clk;
    logic       i_rst;
    logic       i_en;
    logic       i_dir;
    logic       i_clr;
    logic       i_load;
    logic [7:0] lv_a;
    logic [3:0] lv_b;
    logic [7:0] cnt_a;
    logic [3:0] cnt_b;
    logic       tc_a;
    logic       tc_b;
    logic       zero_a;
    logic       zero_b;

    exp_t q[$];
    int   st_a;
    int   st_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    x_counter_updown_mod #(.WIDTH(8), .MOD_MAX(A_MAX), .RESET_VAL(A_RST)) dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_dir(i_dir), .i_clr(i_clr),
        .i_load(i_load), .i_load_val(lv_a), .o_count(cnt_a), .o_tc(tc_a), .o_zero(zero_a)
    );

    x_counter_updown_mod #(.WIDTH(4), .MOD_MAX(B_MAX), .RESET_VAL(B_RST)) dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_dir(i_dir), .i_clr(i_clr),
        .i_load(i_load), .i_load_val(lv_b), .o_count(cnt_b), .o_tc(tc_b), .o_zero(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour in plain modular arithmetic.
    function automatic void model(input int cur, input int maxv, input int rstv,
                                  input bit en, input bit dir, input bit clr, input bit load,
                                  input int lv, output int nxt, output bit tc);
        nxt = cur;
        tc  = 1'b0;
        if (clr) begin
            nxt = rstv;
        end else if (load) begin
            nxt = (lv > maxv) ? maxv : lv;
        end else if (en) begin
            if (SAT) begin
                if (dir) nxt = (cur + 1 > maxv) ? maxv : cur + 1;
                else     nxt = (cur == 0) ? 0 : cur - 1;
                tc = (nxt != cur) && (dir ? (nxt == maxv) : (nxt == 0));
            end else begin
                if (dir) begin
                    nxt = (cur + 1) % (maxv + 1);
                    tc  = (cur == maxv);
                end else begin
                    nxt = (cur + maxv) % (maxv + 1);
                    tc  = (cur == 0);
                end
            end
        end
    endfunction

    task automatic step(input bit en, input bit dir, input bit clr, input bit load,
                        input int lva, input int lvb);
        exp_t e;
        @(negedge clk);
        i_en   = en;
        i_dir  = dir;
        i_clr  = clr;
        i_load = load;
        lv_a   = 8'(lva);
        lv_b   = 4'(lvb);
        model(st_a, A_MAX, A_RST, en, dir, clr, load, lva & 255, e.ca, e.tca);
        model(st_b, B_MAX, B_RST, en, dir, clr, load, lvb & 15, e.cb, e.tcb);
        st_a = e.ca;
        st_b = e.cb;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_count"}, int'(cnt_a), A_RST);
        chk({tag, "_a_tc"}, int'(tc_a), 0);
        chk({tag, "_b_count"}, int'(cnt_b), B_RST);
        chk({tag, "_b_tc"}, int'(tc_b), 0);
    endtask

    // Asserts reset between edges, checks it took effect without a clock edge and holds across one.
    task automatic reset_check();
        @(posedge clk);
        #3;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        i_rst  = 1'b0;
        i_en   = 1'b0;
        i_clr  = 1'b0;
        i_load = 1'b0;
        st_a   = A_RST;
        st_b   = B_RST;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("a_count", int'(cnt_a), e.ca);
                chk("a_tc", int'(tc_a), int'(e.tca));
                chk("a_zero", int'(zero_a), int'(e.ca == 0));
                chk("b_count", int'(cnt_b), e.cb);
                chk("b_tc", int'(tc_b), int'(e.tcb));
                chk("b_zero", int'(zero_b), int'(e.cb == 0));
            end
        end
    end

    initial begin : driver
        int budget;
        i_rst  = 1'b1;
        i_en   = 1'b0;
        i_dir  = 1'b0;
        i_clr  = 1'b0;
        i_load = 1'b0;
        lv_a   = '0;
        lv_b   = '0;
        st_a   = A_RST;
        st_b   = B_RST;
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        i_rst = 1'b0;

        repeat (257) step(1, 1, 0, 0, 0, 0);

        step(1, 1, 1, 1, 5, 5);
        step(1, 1, 0, 1, 5, 5);

        step(0, 0, 0, 1, 14, 14);
        repeat (10) step(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0);

        step(0, 0, 0, 1, 3, 3);
        for (int i = 0; i < 4; i++) step(1, (i % 2) == 0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 8, 8);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        end

        step(0, 0, 0, 1, 9, 9);
        step(1, 1, 0, 0, 0, 0);
        reset_check();

        repeat (20) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/x_counter_updown_mod.md
Name: x_counter_updown_mod

Overview:
- Parametrised up/down modulo counter; next generation of the fixed 8-bit free-running counter.
- Adds configurable width and modulus, count enable, direction select, synchronous clear and parallel load.
- Adds a registered terminal-count pulse for cascading counters and driving dividers/timers on the board.
- Single clock domain; output bits are registered, so the block drops straight into the flop-level netlist flow.

Parameters:
- WIDTH, 8, counter width in bits (1..16).
- MOD_MAX, 255, highest count value; range is 0..MOD_MAX. Must satisfy MOD_MAX <= 2**WIDTH-1 and MOD_MAX >= 1.
- RESET_VAL, 0, value loaded on reset and on clear. Must be <= MOD_MAX.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_en  input  1  count enable; one step per cycle while high.
- i_dir  input  1  direction: 1 = up, 0 = down.
- i_clr  input  1  synchronous clear to RESET_VAL.
- i_load  input  1  synchronous parallel load.
- i_load_val  input  WIDTH  value for load.
- o_count  output  WIDTH  current count, registered.
- o_tc  output  1  terminal-count pulse, registered.
- o_zero  output  1  high when o_count == 0; combinational decode of the register.

Behaviour:
- Reset (async assert, i_rst=1):
  - o_count = RESET_VAL; o_tc = 0.
  - Held while i_rst is high, regardless of the clock.
  - Release is synchronous to the next rising edge; the first update occurs on the first edge with i_rst low.
- Priority per edge, highest first: i_clr > i_load > i_en. Lower-priority inputs are ignored that cycle.
- Clear: o_count <= RESET_VAL; o_tc <= 0.
- Load:
  - o_count <= i_load_val.
  - If i_load_val > MOD_MAX, o_count <= MOD_MAX (clamp).
  - o_tc <= 0.
- Step (i_en=1, no clr/load):
  - Up: count == MOD_MAX -> 0 (wrap), o_tc <= 1; otherwise count+1, o_tc <= 0.
  - Down: count == 0 -> MOD_MAX (wrap), o_tc <= 1; otherwise count-1, o_tc <= 0.
- Idle (i_en=0, no clr/load): o_count holds; o_tc <= 0.
- o_tc timing:
  - Exactly one cycle high, in the same cycle o_count shows the wrapped value.
  - Stays high on consecutive wraps, e.g. MOD_MAX=1 counting continuously.
- Arithmetic:
  - Computed in WIDTH+1 bits, then compared against MOD_MAX.
  - No reliance on natural 2**WIDTH overflow, so non-power-of-two moduli wrap correctly.
- Direction change takes effect on the same edge i_dir is sampled; there is no turnaround latency.
- Reset mid-count: immediate return to RESET_VAL, and any pending o_tc is dropped.
- Elaboration error if the MOD_MAX or RESET_VAL constraints are violated.

Optional Feature:
- Macro: X_COUNTER_UPDOWN_MOD_SAT_EN.
- Defined: saturating mode.
  - Up at MOD_MAX holds MOD_MAX; down at 0 holds 0.
  - o_tc pulses only on the step that first reaches the boundary (count was MOD_MAX-1 going up, or 1 going down).
  - Further enabled steps at the boundary give o_tc = 0.
- Undefined: wrap-around behaviour as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and step:
  - WIDTH=8, MOD_MAX=255, RESET_VAL=0; i_rst pulsed mid-cycle -> o_count=0 and o_tc=0 asynchronously.
  - i_en=1, i_dir=1 for 256 cycles -> counts 0..255 then 0; o_tc high only on the cycle o_count returns to 0; o_zero high at 0.
- Non-power-of-two modulus: WIDTH=4, MOD_MAX=9, up -> sequence 0..9,0; o_tc on the wrap to 0. Down from 0 -> 9, o_tc=1, then 8, o_tc=0.
- Priority: i_clr=1, i_load=1 (i_load_val=5), i_en=1 on the same edge -> o_count=RESET_VAL. Next cycle i_load=1, i_en=1 -> o_count=5, no step.
- Load clamp and hold: WIDTH=4, MOD_MAX=9, load 14 -> o_count=9. i_en=0 for 10 cycles -> stays 9, o_tc=0.
- Direction flip: MOD_MAX=255, count=3, i_dir toggled each cycle with i_en=1 -> 4,3,4,3; o_tc stays 0.
- X_COUNTER_UPDOWN_MOD_SAT_EN defined, MOD_MAX=9, from 8 counting up:
  - 9 with o_tc=1, then 9 with o_tc=0 for all further steps.
  - Down from 1 -> 0 with o_tc=1, then stays 0.
